// File: rtl/ysyx_23060236_btb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_23060236_btb_ctrl_pkg : shared widths and FSM encodings for BTB control
// Rev 1.0
// ============================================================================
package ysyx_23060236_btb_ctrl_pkg;

    localparam int DEF_ADDR_LEN = 32;
    localparam int DEF_QDEPTH   = 2;
    localparam int DEF_CNT_LEN  = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } btb_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060236_btb_updq.sv
`default_nettype none
// ============================================================================
// ysyx_23060236_btb_updq : coalescing FIFO of pending BTB training writes
// Rev 1.0
// ============================================================================
module ysyx_23060236_btb_updq
    import ysyx_23060236_btb_ctrl_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int QDEPTH   = DEF_QDEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                upd_valid,
    input  logic [ADDR_LEN-1:0] upd_pc,
    input  logic [ADDR_LEN-1:0] upd_target,
    input  logic                pop,
    output logic [ADDR_LEN-1:0] head_pc,
    output logic [ADDR_LEN-1:0] head_target,
    output logic                full,
    output logic                empty
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_LEN-1:0] pc_q  [QDEPTH];
    logic [ADDR_LEN-1:0] pc_d  [QDEPTH];
    logic [ADDR_LEN-1:0] tgt_q [QDEPTH];
    logic [ADDR_LEN-1:0] tgt_d [QDEPTH];
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                w_hit;
    logic [PW-1:0]       w_hit_idx;
    logic                w_push;

    // A slot is live when its distance from head is below count. The head
    // being popped this cycle is excluded so a fresh target is never lost.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = QDEPTH - 1; i >= 0; i--) begin
            if ((CW'(PW'(i) - head_q) < cnt_q) && (pc_q[i] == upd_pc) &&
                !(pop && (PW'(i) == head_q))) begin
                w_hit     = 1'b1;
                w_hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        pc_d   = pc_q;
        tgt_d  = tgt_q;
        head_d = head_q;
        tail_d = tail_q;
        w_push = 1'b0;
        if (upd_valid) begin
            if (w_hit) begin
                tgt_d[w_hit_idx] = upd_target;
            end else begin
                pc_d[tail_q]  = upd_pc;
                tgt_d[tail_q] = upd_target;
                tail_d        = tail_q + PW'(1);
                w_push        = 1'b1;
            end
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(w_push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q[i]  <= '0;
                tgt_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            tgt_q  <= tgt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_pc     = pc_q[head_q];
    assign head_target = tgt_q[head_q];
    assign full        = (cnt_q == CW'(QDEPTH));
    assign empty       = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ysyx_23060236_btb_ctrl.sv
`default_nettype none
// ============================================================================
// ysyx_23060236_btb_ctrl : branch resolution, IFU redirect and BTB training
// Rev 1.0
// ============================================================================
module ysyx_23060236_btb_ctrl
    import ysyx_23060236_btb_ctrl_pkg::*;
#(
    parameter int ADDR_LEN = DEF_ADDR_LEN,
    parameter int QDEPTH   = DEF_QDEPTH,
    parameter int CNT_LEN  = DEF_CNT_LEN
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_LEN-1:0] ex_pc,
    input  logic                ex_is_cf,
    input  logic                ex_taken,
    input  logic [ADDR_LEN-1:0] ex_target,
    input  logic [ADDR_LEN-1:0] pred_npc,
    output logic                redirect_valid,
    output logic [ADDR_LEN-1:0] redirect_pc,
    input  logic                redirect_ready,
    input  logic                wr_block,
    output logic                btb_wvalid,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [ADDR_LEN-1:0] btb_wdata,
    output logic [CNT_LEN-1:0]  perf_miss,
    output logic [CNT_LEN-1:0]  perf_upd
);

    btb_ctrl_state_e     state_q, state_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [ADDR_LEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_LEN-1:0]  perf_miss_q, perf_miss_d;
    logic [CNT_LEN-1:0]  perf_upd_q, perf_upd_d;

    logic                w_q_full;
    logic                w_q_empty;
    logic                w_accept;
    logic                w_miss;
    logic                w_need_upd;
    logic [ADDR_LEN-1:0] w_actual_npc;

    assign w_actual_npc = (ex_is_cf & ex_taken) ? ex_target : (ex_pc + ADDR_LEN'(4));
    assign ex_ready     = (state_q == ST_RUN) & ~w_q_full;
    assign w_accept     = ex_valid & ex_ready;
    assign w_miss       = w_accept & (w_actual_npc != pred_npc);
    // Not-taken mispredicts only redirect: the BTB has no way to invalidate.
    assign w_need_upd   = w_accept & ex_is_cf & ex_taken & (pred_npc != ex_target);
    assign btb_wvalid   = ~w_q_empty & ~wr_block;

    ysyx_23060236_btb_updq #(
        .ADDR_LEN (ADDR_LEN),
        .QDEPTH   (QDEPTH)
    ) u_updq (
        .clock       (clock),
        .reset       (reset),
        .upd_valid   (w_need_upd),
        .upd_pc      (ex_pc),
        .upd_target  (ex_target),
        .pop         (btb_wvalid),
        .head_pc     (btb_awaddr),
        .head_target (btb_wdata),
        .full        (w_q_full),
        .empty       (w_q_empty)
    );

    always_comb begin
        state_d          = state_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        case (state_q)
            ST_RUN: begin
                if (w_miss) begin
                    state_d          = ST_REDIR;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = w_actual_npc;
                end
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d          = ST_RUN;
                    redirect_valid_d = 1'b0;
                end
            end
            default: begin
                state_d          = ST_RUN;
                redirect_valid_d = 1'b0;
            end
        endcase

        perf_miss_d = (w_miss && !(&perf_miss_q)) ? perf_miss_q + CNT_LEN'(1) : perf_miss_q;
        perf_upd_d  = (btb_wvalid && !(&perf_upd_q)) ? perf_upd_q + CNT_LEN'(1) : perf_upd_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_RUN;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            perf_miss_q      <= '0;
            perf_upd_q       <= '0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            perf_miss_q      <= perf_miss_d;
            perf_upd_q       <= perf_upd_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign perf_miss      = perf_miss_q;
    assign perf_upd       = perf_upd_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060236_btb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ysyx_23060236_btb_ctrl : bench for the BTB resolution controller
// Rev 1.0
// ============================================================================
module tb_ysyx_23060236_btb_ctrl;

    localparam int QDEPTH = 2;

    logic        clock          = 1'b0;
    logic        reset          = 1'b1;
    logic        ex_valid       = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_pc          = '0;
    logic        ex_is_cf       = 1'b0;
    logic        ex_taken       = 1'b0;
    logic [31:0] ex_target      = '0;
    logic [31:0] pred_npc       = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b0;
    logic        wr_block       = 1'b0;
    logic        btb_wvalid;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic [31:0] perf_miss;
    logic [31:0] perf_upd;

    int checks   = 0;
    int failures = 0;

    ysyx_23060236_btb_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_pc          (ex_pc),
        .ex_is_cf       (ex_is_cf),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .pred_npc       (pred_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .wr_block       (wr_block),
        .btb_wvalid     (btb_wvalid),
        .btb_awaddr     (btb_awaddr),
        .btb_wdata      (btb_wdata),
        .perf_miss      (perf_miss),
        .perf_upd       (perf_upd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a list, redirect as a pending flag.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    bit          model_ok = 1'b0;
    bit          m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_miss;
    logic [31:0] m_upd;
    bit          m_acc;
    bit          m_wv;
    bit          m_is_miss;
    logic [31:0] m_npc;
    int          m_hit;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_redir  = 1'b0;
            m_rpc    = '0;
            m_miss   = '0;
            m_upd    = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_acc     = ex_valid && !m_redir && (mq.size() < QDEPTH);
            m_wv      = (mq.size() != 0) && !wr_block;
            m_npc     = (ex_is_cf && ex_taken) ? ex_target : ex_pc + 32'd4;
            m_is_miss = m_acc && (m_npc != pred_npc);
            if (m_is_miss && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            if (m_acc && ex_is_cf && ex_taken && (pred_npc != ex_target)) begin
                m_hit = -1;
                for (int k = (m_wv ? 1 : 0); k < mq.size(); k++)
                    if (mq[k].pc == ex_pc) m_hit = k;
                if (m_hit >= 0) begin
                    mq[m_hit].tgt = ex_target;
                end else begin
                    m_e.pc  = ex_pc;
                    m_e.tgt = ex_target;
                    mq.push_back(m_e);
                end
            end
            if (m_wv) begin
                void'(mq.pop_front());
                if (m_upd != 32'hFFFF_FFFF) m_upd = m_upd + 1;
            end
            if (m_redir) begin
                if (redirect_ready) m_redir = 1'b0;
            end else if (m_is_miss) begin
                m_redir = 1'b1;
                m_rpc   = m_npc;
            end
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("cmp.ex_ready", 32'(ex_ready), 32'(!m_redir && (mq.size() < QDEPTH)));
            chk("cmp.redirect_valid", 32'(redirect_valid), 32'(m_redir));
            chk("cmp.redirect_pc", redirect_pc, m_rpc);
            chk("cmp.btb_wvalid", 32'(btb_wvalid), 32'((mq.size() != 0) && !wr_block));
            if (mq.size() != 0) begin
                chk("cmp.btb_awaddr", btb_awaddr, mq[0].pc);
                chk("cmp.btb_wdata", btb_wdata, mq[0].tgt);
            end
            chk("cmp.perf_miss", perf_miss, m_miss);
            chk("cmp.perf_upd", perf_upd, m_upd);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic cf, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] pred, input bit rel);
        ex_valid  = 1'b1;
        ex_pc     = pc;
        ex_is_cf  = cf;
        ex_taken  = tk;
        ex_target = tgt;
        pred_npc  = pred;
        tick();
        ex_valid  = 1'b0;
        if (rel) begin
            redirect_ready = 1'b1;
            tick();
            redirect_ready = 1'b0;
        end
    endtask

    localparam logic [31:0] PA = 32'h8000_1000;
    localparam logic [31:0] PB = 32'h8000_1100;

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst.btb_wvalid", 32'(btb_wvalid), 32'd0);
        chk("rst.ex_ready", 32'(ex_ready), 32'd1);
        chk("rst.perf_miss", perf_miss, 32'd0);

        issue(32'h8000_0000, 1, 1, 32'h8000_0100, 32'h8000_0100, 0);
        chk("hit.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("hit.btb_wvalid", 32'(btb_wvalid), 32'd0);

        issue(32'h8000_0010, 1, 1, 32'h8000_0200, 32'h8000_0014, 0);
        chk("tmiss.redirect_valid", 32'(redirect_valid), 32'd1);
        chk("tmiss.redirect_pc", redirect_pc, 32'h8000_0200);
        chk("tmiss.btb_wvalid", 32'(btb_wvalid), 32'd1);
        chk("tmiss.btb_awaddr", btb_awaddr, 32'h8000_0010);
        chk("tmiss.btb_wdata", btb_wdata, 32'h8000_0200);
        chk("tmiss.perf_miss", perf_miss, 32'd1);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("tmiss.cleared", 32'(redirect_valid), 32'd0);
        chk("tmiss.perf_upd", perf_upd, 32'd1);

        issue(32'h8000_0020, 1, 0, 32'h8000_0500, 32'h8000_0300, 0);
        chk("ntmiss.redirect_pc", redirect_pc, 32'h8000_0024);
        chk("ntmiss.btb_wvalid", 32'(btb_wvalid), 32'd0);
        ex_valid  = 1'b1;
        ex_pc     = 32'h8000_0040;
        ex_is_cf  = 1'b0;
        pred_npc  = 32'h0;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("hold.redirect_valid", 32'(redirect_valid), 32'd1);
            chk("hold.redirect_pc", redirect_pc, 32'h8000_0024);
            chk("hold.ex_ready", 32'(ex_ready), 32'd0);
        end
        ex_valid = 1'b0;
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("hold.perf_miss", perf_miss, 32'd2);

        issue(32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0000_0004, 0);
        chk("wrap.redirect_pc", redirect_pc, 32'h0);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;

        wr_block = 1'b1;
        issue(PA, 1, 1, 32'hA000_0000, PA + 4, 1);
        issue(PB, 1, 1, 32'hB000_0000, PB + 4, 1);
        chk("full.ex_ready", 32'(ex_ready), 32'd0);
        chk("full.btb_wvalid", 32'(btb_wvalid), 32'd0);
        wr_block = 1'b0;
        chk("drain1.btb_awaddr", btb_awaddr, PA);
        chk("drain1.btb_wdata", btb_wdata, 32'hA000_0000);
        tick();
        chk("drain2.btb_awaddr", btb_awaddr, PB);
        chk("drain2.btb_wdata", btb_wdata, 32'hB000_0000);
        tick();
        chk("drain.done", 32'(btb_wvalid), 32'd0);
        chk("drain.perf_upd", perf_upd, 32'd3);

        wr_block = 1'b1;
        issue(PA, 1, 1, 32'hA000_0010, PA + 4, 1);
        issue(PA, 1, 1, 32'hA000_0020, PA + 4, 1);
        chk("coal.ex_ready", 32'(ex_ready), 32'd1);
        wr_block = 1'b0;
        chk("coal.btb_awaddr", btb_awaddr, PA);
        chk("coal.btb_wdata", btb_wdata, 32'hA000_0020);
        tick();
        chk("coal.single", 32'(btb_wvalid), 32'd0);
        chk("coal.perf_upd", perf_upd, 32'd4);
        chk("coal.perf_miss", perf_miss, 32'd7);

        wr_block = 1'b1;
        issue(PA, 1, 1, 32'hA000_0030, PA + 4, 1);
        issue(PB, 1, 1, 32'hB000_0030, PB + 4, 0);
        chk("rr.redirect_valid", 32'(redirect_valid), 32'd1);
        wr_block = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr.redirect_valid_clr", 32'(redirect_valid), 32'd0);
        chk("rr.btb_wvalid", 32'(btb_wvalid), 32'd0);
        chk("rr.ex_ready", 32'(ex_ready), 32'd1);
        chk("rr.perf_miss", perf_miss, 32'd0);

        for (int n = 0; n < 400; n++) begin
            ex_valid       = 1'($urandom_range(0, 1));
            ex_pc          = 32'h100 + 32'(4 * $urandom_range(0, 2));
            ex_is_cf       = 1'($urandom_range(0, 1));
            ex_taken       = 1'($urandom_range(0, 1));
            ex_target      = 32'h200 + 32'(16 * $urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       pred_npc = ex_target;
                1:       pred_npc = ex_pc + 32'd4;
                default: pred_npc = 32'h999;
            endcase
            wr_block       = 1'($urandom_range(0, 1));
            redirect_ready = 1'($urandom_range(0, 1));
            tick();
        end

        ex_valid       = 1'b0;
        wr_block       = 1'b0;
        redirect_ready = 1'b1;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
